axis_seq_gen: RTL and testbench

AXIS_SEQ_GEN -- requirements
Module: axis_seq_gen

---
 rtl/axis_seq_gen_pkg.sv | 19 +
 rtl/seq_gen_next_value.sv | 40 ++++
 rtl/axis_seq_gen.sv | 130 +++++++++++++
 tb/tb_axis_seq_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_seq_gen_pkg.sv
// Shared constants for the AXI-Stream sequence generator: mode encodings,
// FSM states and default parameter values.
package axis_seq_gen_pkg;

  parameter int unsigned DefaultDataSize = 32;
  parameter int unsigned DefaultLenWidth = 16;

  // cfg_mode encodings; ModeRsvd behaves like ModeConst
  parameter logic [1:0] ModeGeom  = 2'b00;
  parameter logic [1:0] ModeArith = 2'b01;
  parameter logic [1:0] ModeConst = 2'b10;
  parameter logic [1:0] ModeRsvd  = 2'b11;

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } state_e;

endpackage

// File: rtl/seq_gen_next_value.sv
// Combinational next-value generator: x*step, x+step or x, with a
// full-precision overflow indication.
module seq_gen_next_value
  import axis_seq_gen_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DefaultDataSize
) (
  input  logic [1:0]           mode_i,
  input  logic [DATA_SIZE-1:0] x_i,
  input  logic [DATA_SIZE-1:0] step_i,
  output logic [DATA_SIZE-1:0] next_o,
  output logic                 ovf_o
);

  logic [2*DATA_SIZE-1:0] prod;
  logic [DATA_SIZE:0]     sum;

  assign prod = {{DATA_SIZE{1'b0}}, x_i} * {{DATA_SIZE{1'b0}}, step_i};
  assign sum  = {1'b0, x_i} + {1'b0, step_i};

  always_comb begin
    next_o = x_i;
    ovf_o  = 1'b0;
    case (mode_i)
      ModeGeom: begin
        next_o = prod[DATA_SIZE-1:0];
        ovf_o  = |prod[2*DATA_SIZE-1:DATA_SIZE];
      end
      ModeArith: begin
        next_o = sum[DATA_SIZE-1:0];
        ovf_o  = sum[DATA_SIZE];
      end
      default: begin
        next_o = x_i;
        ovf_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/axis_seq_gen.sv
// AXI-Stream master emitting packets of geometric, arithmetic or constant
// sequences; config is latched once per packet.
module axis_seq_gen
  import axis_seq_gen_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DefaultDataSize,
  parameter int unsigned LEN_WIDTH = DefaultLenWidth
) (
  input  logic                   m00_axis_aclk,
  input  logic                   m00_axis_areset,
  input  logic                   m00_axis_enable,
  input  logic [1:0]             cfg_mode,
  input  logic [DATA_SIZE-1:0]   cfg_seed,
  input  logic [DATA_SIZE-1:0]   cfg_step,
  input  logic [LEN_WIDTH-1:0]   cfg_pkt_len,
  input  logic                   m00_axis_tready,
  output logic [DATA_SIZE-1:0]   m00_axis_tdata,
  output logic [DATA_SIZE/8-1:0] m00_axis_tstrb,
  output logic                   m00_axis_tvalid,
  output logic                   m00_axis_tlast,
  output logic                   ovf_flag,
  output logic                   busy
);

  state_e                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [DATA_SIZE-1:0]   step_q, step_d;
  logic [DATA_SIZE-1:0]   tdata_q, tdata_d;
  logic [LEN_WIDTH-1:0]   last_idx_q, last_idx_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  logic [DATA_SIZE-1:0]   next_val;
  logic                   next_ovf;
  logic                   valid;
  logic                   is_last;
  logic                   handshake;
  logic                   load;
  logic                   advance;

  seq_gen_next_value #(
    .DATA_SIZE(DATA_SIZE)
  ) u_next_value (
    .mode_i(mode_q),
    .x_i   (tdata_q),
    .step_i(step_q),
    .next_o(next_val),
    .ovf_o (next_ovf)
  );

  assign valid     = (state_q == StStream);
  assign is_last   = (cnt_q == last_idx_q);
  assign handshake = valid & m00_axis_tready;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    step_d     = step_q;
    tdata_d    = tdata_q;
    last_idx_d = last_idx_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    load       = 1'b0;
    advance    = 1'b0;

    unique case (state_q)
      StIdle: begin
        load = m00_axis_enable;
      end
      StStream: begin
        if (handshake) begin
          if (!is_last) begin
            advance = 1'b1;
          end else if (m00_axis_enable) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d    = StStream;
      mode_d     = cfg_mode;
      step_d     = cfg_step;
      tdata_d    = cfg_seed;
      cnt_d      = '0;
      ovf_d      = 1'b0;
      // A zero length is a single-beat packet
      last_idx_d = (cfg_pkt_len == '0) ? '0 : cfg_pkt_len - LEN_WIDTH'(1);
    end

    if (advance) begin
      tdata_d = next_val;
      cnt_d   = cnt_q + LEN_WIDTH'(1);
      ovf_d   = ovf_q | next_ovf;
    end
  end

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state_q    <= StIdle;
      mode_q     <= ModeGeom;
      step_q     <= '0;
      tdata_q    <= '0;
      last_idx_q <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      step_q     <= step_d;
      tdata_q    <= tdata_d;
      last_idx_q <= last_idx_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tstrb  = '1;
  assign m00_axis_tvalid = valid;
  assign m00_axis_tlast  = valid & is_last;
  assign ovf_flag        = ovf_q;
  assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_axis_seq_gen.sv
// Directed bench for axis_seq_gen with an expected-beat scoreboard popped on
// every handshake.
module tb_axis_seq_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          areset;
  logic          enable;
  logic [1:0]    mode;
  logic [DW-1:0] seed;
  logic [DW-1:0] step;
  logic [LW-1:0] pkt_len;
  logic          tready;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tstrb;
  logic          tvalid;
  logic          tlast;
  logic          ovf;
  logic          busy;

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  axis_seq_gen #(
    .DATA_SIZE(DW),
    .LEN_WIDTH(LW)
  ) dut (
    .m00_axis_aclk  (clk),
    .m00_axis_areset(areset),
    .m00_axis_enable(enable),
    .cfg_mode       (mode),
    .cfg_seed       (seed),
    .cfg_step       (step),
    .cfg_pkt_len    (pkt_len),
    .m00_axis_tready(tready),
    .m00_axis_tdata (tdata),
    .m00_axis_tstrb (tstrb),
    .m00_axis_tvalid(tvalid),
    .m00_axis_tlast (tlast),
    .ovf_flag       (ovf),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Score the beat that handshakes at the coming edge, then advance one cycle
  task automatic cyc();
    beat_t e;
    if (tvalid && tready && !areset) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("beat_tdata", 32'(tdata), 32'(e.data));
        chk("beat_tlast", 32'(tlast), 32'(e.last));
        chk("beat_tstrb", 32'(tstrb), 32'd1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      chk({tag, "_no_bubble"}, 32'(tvalid), 32'd1);
      cyc();
      n++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tvalid"}, 32'(tvalid), 32'd0);
    chk({tag, "_tlast"}, 32'(tlast), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset  = 1'b1;
    enable  = 1'b0;
    mode    = 2'b00;
    seed    = '0;
    step    = '0;
    pkt_len = '0;
    tready  = 1'b1;
    cyc();
    cyc();
    chk_idle("reset");
    chk("reset_tdata", 32'(tdata), 32'd0);
    chk("reset_tstrb", 32'(tstrb), 32'd1);
    chk("reset_ovf", 32'(ovf), 32'd0);
    areset = 1'b0;
    cyc();

    // Geometric 1,3,9,27 with a one-cycle enable pulse; config scrambled mid-packet
    mode = 2'b00; seed = 8'd1; step = 8'd3; pkt_len = 16'd4;
    push(8'd1, 1'b0); push(8'd3, 1'b0); push(8'd9, 1'b0); push(8'd27, 1'b1);
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    chk("geom_first_tvalid", 32'(tvalid), 32'd1);
    chk("geom_first_tdata", 32'(tdata), 32'd1);
    chk("geom_first_busy", 32'(busy), 32'd1);
    chk("geom_first_ovf", 32'(ovf), 32'd0);
    mode = 2'b01; seed = 8'd99; step = 8'd2; pkt_len = 16'd9;
    drain("geom");
    chk_idle("geom_end");

    // Backpressure: tready low for 3 cycles while beat 2 is presented
    mode = 2'b00; seed = 8'd1; step = 8'd3; pkt_len = 16'd4;
    push(8'd1, 1'b0); push(8'd3, 1'b0); push(8'd9, 1'b0); push(8'd27, 1'b1);
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    cyc();
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_tdata", 32'(tdata), 32'd3);
      chk("bp_hold_tvalid", 32'(tvalid), 32'd1);
      chk("bp_hold_tlast", 32'(tlast), 32'd0);
      cyc();
    end
    tready = 1'b1;
    drain("bp");
    chk_idle("bp_end");

    // Arithmetic wrap: 200, 44, 144 with overflow set by 200+100
    mode = 2'b01; seed = 8'd200; step = 8'd100; pkt_len = 16'd3;
    push(8'd200, 1'b0); push(8'd44, 1'b0); push(8'd144, 1'b1);
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    chk("wrap_first_ovf", 32'(ovf), 32'd0);
    cyc();
    cyc();
    chk("wrap_beat3_tdata", 32'(tdata), 32'd144);
    chk("wrap_beat3_ovf", 32'(ovf), 32'd1);
    drain("wrap");
    chk_idle("wrap_end");
    chk("wrap_ovf_sticky", 32'(ovf), 32'd1);

    // len=0 with enable held: single-beat constant packets, no gaps
    mode = 2'b10; seed = 8'h5A; step = 8'd7; pkt_len = 16'd0;
    enable = 1'b1;
    cyc();
    chk("b2b_ovf_cleared", 32'(ovf), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_tvalid", 32'(tvalid), 32'd1);
      chk("b2b_tlast", 32'(tlast), 32'd1);
      push(8'h5A, 1'b1);
      cyc();
    end
    // Relatch on the final handshake picks up new config: reserved mode is constant
    mode = 2'b11; seed = 8'h33; step = 8'd7; pkt_len = 16'd2;
    push(8'h5A, 1'b1);
    cyc();
    enable = 1'b0;
    chk("rsvd_first_tdata", 32'(tdata), 32'h33);
    push(8'h33, 1'b0); push(8'h33, 1'b1);
    drain("rsvd");
    chk_idle("rsvd_end");

    // Reset on beat 2 aborts the packet; fresh enable restarts from seed
    mode = 2'b01; seed = 8'd10; step = 8'd5; pkt_len = 16'd4;
    push(8'd10, 1'b0);
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    cyc();
    chk("rst_beat2_tdata", 32'(tdata), 32'd15);
    areset = 1'b1;
    enable = 1'b1;
    cyc();
    chk_idle("rst_mid");
    chk("rst_mid_tdata", 32'(tdata), 32'd0);
    chk("rst_mid_ovf", 32'(ovf), 32'd0);
    chk("rst_mid_sb", 32'(exp_q.size()), 32'd0);
    areset = 1'b0;
    push(8'd10, 1'b0); push(8'd15, 1'b0); push(8'd20, 1'b0); push(8'd25, 1'b1);
    cyc();
    enable = 1'b0;
    chk("restart_tdata", 32'(tdata), 32'd10);
    drain("restart");
    chk_idle("restart_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
